mips_multicycle_core: RTL and testbench

Parametrised multicycle MIPS core combining the datapath and control FSM into one block, with an external single-port memory behind a req/ready handshake that supports wait states. It executes a MIPS-I subset: add, sub, and, or, slt, lw, sw, beq, addi and j. It has an internal 32×32 register file, and trap-on-illegal-opcode is selectable at compile time. It replaces the fixed-latency datapath/controller pair at the top of the processor.

---
 rtl/mips_multicycle_core.sv | 133 +++++++++++++
 tb/tb_mips_multicycle_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-I subset core with req/ready memory port.
// Define MIPS_CORE_TRAP_EN to halt on illegal opcodes; otherwise they retire as NOPs.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_instr_retired,
    output logic              o_halted,
    output logic [31:0]       o_pc_dbg
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;
`ifdef MIPS_CORE_TRAP_EN
    localparam state_t S_ILL = S_HALT;
    localparam logic ILL_RETIRE = 1'b0;
`else
    localparam state_t S_ILL = S_FETCH;
    localparam logic ILL_RETIRE = 1'b1;
`endif
    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0] r_rf [32];
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_rf_waddr;
    logic [31:0] w_simm, w_alu_res, w_rf_wdata, w_addr;
    logic        w_rtype_ok, w_illegal, w_rf_we;
    state_t      w_dec_next;
    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rtype_ok = w_funct == 6'h20 || w_funct == 6'h22 || w_funct == 6'h24 ||
                        w_funct == 6'h25 || w_funct == 6'h2A;
    assign w_illegal = !((w_op == 6'h00 && w_rtype_ok) || w_op == 6'h23 || w_op == 6'h2B ||
                         w_op == 6'h04 || w_op == 6'h08 || w_op == 6'h02);
    always_comb begin
        w_dec_next = w_illegal ? S_ILL :
                     w_op == 6'h00 ? S_EXEC :
                     (w_op == 6'h23 || w_op == 6'h2B) ? S_MEMADR :
                     w_op == 6'h04 ? S_BRANCH :
                     w_op == 6'h08 ? S_ADDIEX : S_JUMP;
        w_alu_res = w_funct == 6'h20 ? r_a + r_b :
                    w_funct == 6'h22 ? r_a - r_b :
                    w_funct == 6'h24 ? r_a & r_b :
                    w_funct == 6'h25 ? r_a | r_b :
                    {31'd0, $signed(r_a) < $signed(r_b)};
    end
    assign w_rf_we    = r_state == S_MEMWB || r_state == S_ALUWB || r_state == S_ADDIWB;
    assign w_rf_waddr = r_state == S_ALUWB ? w_rd : w_rt;
    assign w_rf_wdata = r_state == S_MEMWB ? r_mdr : r_alu;
    // Memory outputs come only from state and registers; reset gates req/we off at once.
    assign w_addr      = r_state == S_FETCH ? r_pc : r_alu;
    assign o_mem_addr  = w_addr[ADDR_W-1:0];
    assign o_mem_req   = i_rst_n && (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR);
    assign o_mem_we    = i_rst_n && r_state == S_MEMWR;
    assign o_mem_wdata = r_b;
    assign o_pc_dbg    = r_pc;
    assign o_halted    = r_state == S_HALT;
    assign o_instr_retired = w_rf_we || r_state == S_BRANCH || r_state == S_JUMP ||
                             (r_state == S_MEMWR && i_mem_ready) ||
                             (r_state == S_DECODE && w_illegal && ILL_RETIRE);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rf_we && w_rf_waddr != 5'd0) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (i_mem_ready) begin
                    r_ir    <= i_mem_rdata;
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a     <= r_rf[w_rs];
                    r_b     <= r_rf[w_rt];
                    r_alu   <= r_pc + (w_simm << 2);
                    r_state <= w_dec_next;
                end
                S_MEMADR: begin
                    r_alu   <= r_a + w_simm;
                    r_state <= w_op == 6'h23 ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: if (i_mem_ready) begin
                    r_mdr   <= i_mem_rdata;
                    r_state <= S_MEMWB;
                end
                S_MEMWR: if (i_mem_ready) r_state <= S_FETCH;
                S_EXEC: begin
                    r_alu   <= w_alu_res;
                    r_state <= S_ALUWB;
                end
                S_ADDIEX: begin
                    r_alu   <= r_a + w_simm;
                    r_state <= S_ADDIWB;
                end
                S_BRANCH: begin
                    if (r_a == r_b) r_pc <= r_alu;
                    r_state <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs against a wait-state memory model.
// A second instance with a high RESET_PC exercises jump region bits.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retired, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
    logic        d2_req, d2_we, d2_ret, d2_halted;
    logic [31:0] d2_addr, d2_wdata, d2_pc;
    logic [31:0] mem [256];
    int          checks = 0, failures = 0;
    int          waits = 0, wcnt = 0, cyc = 0, stab_err = 0;
    int          ret_q[$];
    logic [31:0] rd_q[$];
    logic        pend = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;
    localparam logic [31:0] HALT_LOOP = 32'h1000_FFFF;

    always #5 clk = ~clk;

    mips_multicycle_core u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .i_mem_ready(mem_ready), .o_instr_retired(retired), .o_halted(halted), .o_pc_dbg(pc_dbg)
    );
    mips_multicycle_core #(.RESET_PC(32'h8000_0010)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(d2_req), .o_mem_we(d2_we),
        .o_mem_addr(d2_addr), .o_mem_wdata(d2_wdata), .i_mem_rdata(32'h0800_0040),
        .i_mem_ready(1'b1), .o_instr_retired(d2_ret), .o_halted(d2_halted), .o_pc_dbg(d2_pc)
    );

    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
        if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end

    always @(negedge clk) begin
        if (retired) ret_q.push_back(cyc);
        if (mem_req && mem_ready && !mem_we) rd_q.push_back(mem_addr);
        if (pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wd)))
            stab_err++;
        pend = mem_req && !mem_ready;
        p_addr = mem_addr;
        p_we = mem_we;
        p_wd = mem_wdata;
    end

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT_LOOP;
    endtask

    // Leaves reset released just after a falling edge; first cycle is the fetch cycle.
    task automatic do_reset(input int w);
        rst_n = 1'b0;
        waits = w;
        @(negedge clk);
        ret_q.delete();
        rd_q.delete();
        stab_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        rst_n = 1'b0;
        waits = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        checks++; if (retired !== 1'b0) begin failures++; $display("FAIL rst_retired got=%b exp=0", retired); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
        checks++; if (pc_dbg !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_dbg); end
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0)
            begin failures++; $display("FAIL first_fetch got req=%b we=%b addr=%h exp 1 0 0", mem_req, mem_we, mem_addr); end
    endtask

    task automatic test_addi_add();
        clear_mem();
        mem[0] = f_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = f_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = f_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = f_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        mem[32] = 32'hDEAD_BEEF;
        do_reset(0);
        repeat (11) @(negedge clk);
        #1;
        checks++; if (ret_q.size() != 3) begin failures++; $display("FAIL alu_retire_count got=%0d exp=3", ret_q.size()); end
        checks++; if (ret_q.size() >= 3 && (ret_q[1] - ret_q[0] != 4 || ret_q[2] - ret_q[1] != 4))
            begin failures++; $display("FAIL alu_cpi got=%0d,%0d exp=4,4", ret_q[1] - ret_q[0], ret_q[2] - ret_q[1]); end
        checks++; if (pc_dbg !== 32'hC) begin failures++; $display("FAIL alu_pc got=%h exp=0000000c", pc_dbg); end
        repeat (8) @(negedge clk);
        checks++; if (mem[32] !== 32'h2) begin failures++; $display("FAIL alu_r3 got=%h exp=00000002", mem[32]); end
    endtask

    task automatic test_ldst_waits();
        clear_mem();
        mem[0] = f_i(6'h08, 5'd0, 5'd1, 16'h0100);
        mem[1] = f_i(6'h2B, 5'd1, 5'd1, 16'h0008);
        mem[2] = f_i(6'h23, 5'd1, 5'd4, 16'h0008);
        mem[3] = f_i(6'h2B, 5'd0, 5'd4, 16'h0084);
        mem[66] = 32'h5555_5555;
        mem[33] = 32'hDEAD_BEEF;
        do_reset(2);
        repeat (45) @(negedge clk);
        #1;
        checks++; if (mem[66] !== 32'h100) begin failures++; $display("FAIL sw_data got=%h exp=00000100", mem[66]); end
        checks++; if (mem[33] !== 32'h100) begin failures++; $display("FAIL lw_data got=%h exp=00000100", mem[33]); end
        checks++; if (ret_q.size() < 4) begin failures++; $display("FAIL ldst_retires got=%0d exp>=4", ret_q.size()); end
        else begin
            checks++; if (ret_q[1] - ret_q[0] != 8) begin failures++; $display("FAIL sw_cycles got=%0d exp=8", ret_q[1] - ret_q[0]); end
            checks++; if (ret_q[2] - ret_q[1] != 9) begin failures++; $display("FAIL lw_cycles got=%0d exp=9", ret_q[2] - ret_q[1]); end
        end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL wait_stable got=%0d exp=0", stab_err); end
    endtask

    task automatic test_branch(input logic eq);
        logic [31:0] exp_pc;
        exp_pc = eq ? 32'h1C : 32'h24;
        clear_mem();
        mem[0] = f_i(6'h08, 5'd0, 5'd1, 16'd7);
        mem[1] = f_i(6'h08, 5'd0, 5'd2, eq ? 16'd7 : 16'd8);
        mem[2] = 32'h0800_0008;
        mem[8] = f_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
        do_reset(0);
        repeat (25) @(negedge clk);
        #1;
        checks++; if (rd_q.size() < 5 || rd_q[3] !== 32'h20 || rd_q[4] !== exp_pc)
            begin failures++; $display("FAIL beq_target eq=%b got=%h exp=%h", eq, rd_q.size() >= 5 ? rd_q[4] : 32'hx, exp_pc); end
        checks++; if (ret_q.size() < 4 || ret_q[3] - ret_q[2] != 3 || ret_q[2] - ret_q[1] != 3)
            begin failures++; $display("FAIL beq_j_cycles eq=%b got=%0d exp=3", eq, ret_q.size() >= 4 ? ret_q[3] - ret_q[2] : -1); end
    endtask

    task automatic test_jump();
        do_reset(0);
        #1;
        checks++; if (d2_req !== 1'b1 || d2_addr !== 32'h8000_0010)
            begin failures++; $display("FAIL j_first_fetch got=%h exp=80000010", d2_addr); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (d2_req !== 1'b1 || d2_addr !== 32'h8000_0100)
            begin failures++; $display("FAIL j_target got=%h exp=80000100", d2_addr); end
    endtask

    task automatic test_rtype_r0();
        logic [31:0] exp_v [6];
        exp_v = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h1, 32'hFFFF_FFFF};
        clear_mem();
        mem[0]  = f_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
        mem[1]  = f_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[2]  = f_r(5'd1, 5'd2, 5'd3, 6'h2A);
        mem[3]  = f_r(5'd2, 5'd1, 5'd5, 6'h2A);
        mem[4]  = f_r(5'd1, 5'd1, 5'd0, 6'h20);
        mem[5]  = f_r(5'd2, 5'd1, 5'd6, 6'h22);
        mem[6]  = f_r(5'd1, 5'd2, 5'd7, 6'h24);
        mem[7]  = f_r(5'd1, 5'd2, 5'd8, 6'h25);
        mem[8]  = f_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        mem[9]  = f_i(6'h2B, 5'd0, 5'd5, 16'h0084);
        mem[10] = f_i(6'h2B, 5'd0, 5'd0, 16'h0088);
        mem[11] = f_i(6'h2B, 5'd0, 5'd6, 16'h008C);
        mem[12] = f_i(6'h2B, 5'd0, 5'd7, 16'h0090);
        mem[13] = f_i(6'h2B, 5'd0, 5'd8, 16'h0094);
        for (int i = 32; i < 38; i++) mem[i] = 32'hDEAD_BEEF;
        do_reset(0);
        repeat (80) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[32 + i] !== exp_v[i])
                begin failures++; $display("FAIL rtype_store_%0d got=%h exp=%h", i, mem[32 + i], exp_v[i]); end
        end
    endtask

    task automatic test_reset_mid_memwr();
        int n;
        clear_mem();
        mem[0] = f_i(6'h2B, 5'd0, 5'd0, 16'h0090);
        mem[36] = 32'hDEAD_BEEF;
        do_reset(10);
        n = 0;
        while (!mem_we && n < 20) begin @(negedge clk); n++; end
        checks++; if (!mem_we) begin failures++; $display("FAIL memwr_timeout got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0)
            begin failures++; $display("FAIL async_req got req=%b we=%b exp 0 0", mem_req, mem_we); end
        @(negedge clk);
        waits = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0)
            begin failures++; $display("FAIL post_reset_fetch got addr=%h req=%b exp=00000000 1", mem_addr, mem_req); end
        checks++; if (mem[36] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL aborted_store got=%h exp=deadbeef", mem[36]); end
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = 32'hFC00_0000;
        do_reset(0);
        repeat (2) @(negedge clk);
        #1;
`ifdef MIPS_CORE_TRAP_EN
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0)
            begin failures++; $display("FAIL trap_halt got halted=%b req=%b exp 1 0", halted, mem_req); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (ret_q.size() != 0 || rd_q.size() != 1)
            begin failures++; $display("FAIL trap_quiet got retires=%0d reads=%0d exp 0 1", ret_q.size(), rd_q.size()); end
`else
        checks++; if (ret_q.size() != 1) begin failures++; $display("FAIL nop_retire got=%0d exp=1", ret_q.size()); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || halted !== 1'b0)
            begin failures++; $display("FAIL nop_next_fetch got=%h halted=%b exp=00000004 0", mem_addr, halted); end
`endif
    endtask

    initial begin
        test_reset();
        test_addi_add();
        test_ldst_waits();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump();
        test_rtype_r0();
        test_reset_mid_memwr();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
